// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Fetch stage in front of the opcode decoder. Owns the PC, issues word
//   requests to instruction memory over a req/ack handshake, and hands one
//   instruction per transfer to decode over valid/ready. A 1-entry skid
//   buffer catches the word that returns while decode is stalled. Redirects
//   from downstream (jumps / taken branches) restart fetch at a new PC.
//
// Ports
//   clk, reset              clock (rising edge), async active-low reset
//   redirect, redirect_pc   refetch request and target (low two bits ignored)
//   imem_req, imem_addr     fetch request and word-aligned byte address
//   imem_ack, imem_data     request completion and returned instruction
//   if_valid, id_ready      decode handshake (transfer = if_valid & id_ready)
//   if_instr, if_opcode     instruction to decode and its opcode field
//   if_pc, if_pc_plus4      address of if_instr and its link value
module instr_fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               if_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [5:0]         if_opcode,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [ADDR_W-1:0]  if_pc_plus4
);

  typedef enum logic [1:0] {IDLE, FETCH, STALL} state_t;

  localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(4);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   pc, pc_nxt;
  // drop marks an outstanding request whose word must be thrown away because
  // a redirect arrived before its ack; held_addr keeps that request's address
  // on the bus until memory completes it.
  logic                drop, drop_nxt;
  logic [ADDR_W-1:0]   held_addr, held_addr_nxt;
  logic                skid_valid, skid_valid_nxt;
  logic [INSTR_W-1:0]  skid_instr, skid_instr_nxt;
  logic [ADDR_W-1:0]   skid_pc, skid_pc_nxt;
  logic                out_valid, out_valid_nxt;
  logic [INSTR_W-1:0]  out_instr, out_instr_nxt;
  logic [ADDR_W-1:0]   out_pc, out_pc_nxt;
  logic [ADDR_W-1:0]   out_pc4, out_pc4_nxt;
  logic                out_free;

  // NOTE: every signal this block drives gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    drop_nxt       = drop;
    held_addr_nxt  = held_addr;
    skid_valid_nxt = skid_valid;
    skid_instr_nxt = skid_instr;
    skid_pc_nxt    = skid_pc;
    out_valid_nxt  = out_valid;
    out_instr_nxt  = out_instr;
    out_pc_nxt     = out_pc;
    out_pc4_nxt    = out_pc4;

    imem_req  = (state == FETCH);
    imem_addr = drop ? held_addr : pc;
    out_free  = !out_valid || id_ready;

    // A completed transfer empties the output register unless refilled below.
    if (out_valid && id_ready) out_valid_nxt = 1'b0;

    unique case (state)
      IDLE: state_nxt = FETCH;
      FETCH: begin
        if (imem_ack) begin
          if (drop) begin
            drop_nxt = 1'b0;
          end else if (out_free) begin
            out_valid_nxt = 1'b1;
            out_instr_nxt = imem_data;
            out_pc_nxt    = pc;
            out_pc4_nxt   = pc + WORD_BYTES;
            pc_nxt        = pc + WORD_BYTES;
          end else begin
            skid_valid_nxt = 1'b1;
            skid_instr_nxt = imem_data;
            skid_pc_nxt    = pc;
            pc_nxt         = pc + WORD_BYTES;
            state_nxt      = STALL;
          end
        end
      end
      STALL: begin
        if (id_ready) begin
          out_valid_nxt  = 1'b1;
          out_instr_nxt  = skid_instr;
          out_pc_nxt     = skid_pc;
          out_pc4_nxt    = skid_pc + WORD_BYTES;
          skid_valid_nxt = 1'b0;
          state_nxt      = FETCH;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Redirect overrides everything above. An ack in the same cycle simply
    // discards its word; an unacked request stays on the bus until memory
    // answers, and its word is dropped then.
    if (redirect) begin
      pc_nxt         = {redirect_pc[ADDR_W-1:2], 2'b00};
      out_valid_nxt  = 1'b0;
      skid_valid_nxt = 1'b0;
      if (state == FETCH) begin
        if (imem_ack) begin
          drop_nxt = 1'b0;
        end else begin
          drop_nxt      = 1'b1;
          held_addr_nxt = imem_addr;
        end
      end
      if (state != IDLE) state_nxt = FETCH;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      drop       <= 1'b0;
      held_addr  <= RESET_PC;
      skid_valid <= 1'b0;
      out_valid  <= 1'b0;
      out_instr  <= '0;
      out_pc     <= '0;
      out_pc4    <= '0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      drop       <= drop_nxt;
      held_addr  <= held_addr_nxt;
      skid_valid <= skid_valid_nxt;
      out_valid  <= out_valid_nxt;
      out_instr  <= out_instr_nxt;
      out_pc     <= out_pc_nxt;
      out_pc4    <= out_pc4_nxt;
    end
  end

  // NOTE: the skid payload carries no reset; skid_valid alone qualifies it,
  // so leaving the data flops reset-free is safe.
  always_ff @(posedge clk) begin
    skid_instr <= skid_instr_nxt;
    skid_pc    <= skid_pc_nxt;
  end

  assign if_valid    = out_valid;
  assign if_instr    = out_instr;
  assign if_opcode   = out_instr[INSTR_W-1 -: 6];
  assign if_pc       = out_pc;
  assign if_pc_plus4 = out_pc4;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit (ADDR_W=8 so PC wrap is reachable).
// Memory model: word array with a programmable ack latency. Reference model:
// decode must see the instruction stream mem[p], mem[p+4], ... starting at the
// reset PC and restarting at each redirect target, with no gaps or repeats.
module tb_instr_fetch_unit;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 32;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               redirect = 1'b0;
  logic [ADDR_W-1:0]  redirect_pc = '0;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_data;
  logic               if_valid;
  logic               id_ready = 1'b1;
  logic [INSTR_W-1:0] if_instr;
  logic [5:0]         if_opcode;
  logic [ADDR_W-1:0]  if_pc;
  logic [ADDR_W-1:0]  if_pc_plus4;

  int tests = 0;
  int fails = 0;

  logic [INSTR_W-1:0] mem [64];
  int lat = 0;
  int wait_cnt = 0;

  instr_fetch_unit #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC(8'h00)) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_data(imem_data), .if_valid(if_valid), .id_ready(id_ready),
    .if_instr(if_instr), .if_opcode(if_opcode), .if_pc(if_pc),
    .if_pc_plus4(if_pc_plus4)
  );

  always #5 clk = ~clk;

  // Instruction memory: ack once the request has waited lat cycles.
  assign imem_ack  = imem_req && (wait_cnt >= lat);
  assign imem_data = imem_ack ? mem[imem_addr[7:2]] : 32'hDEAD_BEEF;
  always @(posedge clk) wait_cnt <= (imem_req && !imem_ack) ? wait_cnt + 1 : 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model / per-cycle compare ----------------
  logic [ADDR_W-1:0]  exp_pc = '0;
  logic               prev_redirect = 1'b0;
  logic               prev_hold_out = 1'b0;
  logic               prev_hold_req = 1'b0;
  logic [INSTR_W-1:0] held_instr;
  logic [ADDR_W-1:0]  held_pc, held_addr;
  int                 n_xfer = 0;

  always @(negedge clk) begin
    if (!reset) begin
      exp_pc        = 8'h00;
      prev_redirect = 1'b0;
      prev_hold_out = 1'b0;
      prev_hold_req = 1'b0;
    end else begin
      if (prev_redirect)
        check("valid_after_redirect", {31'b0, if_valid}, 32'd0);
      else if (prev_hold_out) begin
        check("hold_valid", {31'b0, if_valid}, 32'd1);
        check("hold_instr", if_instr, held_instr);
        check("hold_pc", {24'b0, if_pc}, {24'b0, held_pc});
      end
      if (prev_hold_req) begin
        check("req_held", {31'b0, imem_req}, 32'd1);
        check("addr_held", {24'b0, imem_addr}, {24'b0, held_addr});
      end
      if (if_valid && id_ready) begin
        n_xfer++;
        check("stream_pc", {24'b0, if_pc}, {24'b0, exp_pc});
        check("stream_instr", if_instr, mem[exp_pc[7:2]]);
        check("stream_opcode", {26'b0, if_opcode}, {26'b0, mem[exp_pc[7:2]][31:26]});
        check("stream_pc4", {24'b0, if_pc_plus4}, {24'b0, 8'(exp_pc + 8'd4)});
        exp_pc = exp_pc + 8'd4;
      end
      if (redirect) exp_pc = {redirect_pc[7:2], 2'b00};
      prev_redirect = redirect;
      prev_hold_out = if_valid && !id_ready;
      prev_hold_req = imem_req && !imem_ack;
      held_instr    = if_instr;
      held_pc       = if_pc;
      held_addr     = imem_addr;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    for (int i = 0; i < 64; i++)
      mem[i] = {6'(i + 3), 26'(32'(i) * 32'h0002_4D1B)};

    // 1: zero-latency memory, decode always ready.
    lat = 0;
    id_ready = 1'b1;
    #3;
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_addr", {24'b0, imem_addr}, 32'h00);
    check("rst_valid", {31'b0, if_valid}, 32'd0);
    check("rst_instr", if_instr, 32'h0);
    tick(); tick();
    reset = 1'b1;
    for (int n = 0; n < 10 && !if_valid; n++) tick();
    check("t1_valid", {31'b0, if_valid}, 32'd1);
    check("t1_instr_a", if_instr, 32'h0C00_0000);
    check("t1_pc_a", {24'b0, if_pc}, 32'h00);
    check("t1_pc4_a", {24'b0, if_pc_plus4}, 32'h04);
    check("t1_opcode_a", {26'b0, if_opcode}, 32'd3);
    tick();
    check("t1_instr_b", if_instr, 32'h1002_4D1B);
    check("t1_pc_b", {24'b0, if_pc}, 32'h04);
    check("t1_pc4_b", {24'b0, if_pc_plus4}, 32'h08);
    tick();
    check("t1_instr_c", if_instr, 32'h1404_9A36);
    check("t1_pc_c", {24'b0, if_pc}, 32'h08);
    check("t1_pc4_c", {24'b0, if_pc_plus4}, 32'h0C);

    // 2: three cycles of backpressure while 0x08 is presented.
    id_ready = 1'b0;
    tick(); tick(); tick();
    check("t2_stall_req", {31'b0, imem_req}, 32'd0);
    check("t2_hold_pc", {24'b0, if_pc}, 32'h08);
    id_ready = 1'b1;
    tick();
    check("t2_skid_pc", {24'b0, if_pc}, 32'h0C);
    check("t2_refetch_req", {31'b0, imem_req}, 32'd1);
    check("t2_refetch_addr", {24'b0, imem_addr}, 32'h10);
    tick();
    check("t2_next_pc", {24'b0, if_pc}, 32'h10);

    // 5: PC wrap at 0xFC.
    redirect = 1'b1;
    redirect_pc = 8'hF4;
    tick();
    redirect = 1'b0;
    for (int n = 0; n < 10 && !(if_valid && if_pc == 8'hFC); n++) tick();
    check("t5_pc_fc", {24'b0, if_pc}, 32'hFC);
    check("t5_pc4_wrap", {24'b0, if_pc_plus4}, 32'h00);
    check("t5_addr_wrap", {24'b0, imem_addr}, 32'h00);
    tick();
    check("t5_pc_0", {24'b0, if_pc}, 32'h00);
    check("t5_instr_0", if_instr, 32'h0C00_0000);

    // 3: latency 2, redirect while the 0x08 request is outstanding.
    reset = 1'b0;
    lat = 2;
    tick(); tick();
    reset = 1'b1;
    for (int n = 0; n < 40 && !(imem_req && imem_addr == 8'h08); n++) tick();
    check("t3_req_08", {24'b0, imem_addr}, 32'h08);
    tick();
    check("t3_no_ack", {31'b0, imem_ack}, 32'd0);
    redirect = 1'b1;
    redirect_pc = 8'h40;
    tick();
    redirect = 1'b0;
    check("t3_addr_held", {24'b0, imem_addr}, 32'h08);
    check("t3_ack_old", {31'b0, imem_ack}, 32'd1);
    tick();
    check("t3_addr_new", {24'b0, imem_addr}, 32'h40);
    for (int n = 0; n < 10 && !if_valid; n++) tick();
    check("t3_pc_new", {24'b0, if_pc}, 32'h40);

    // 4: redirect to 0x23 in the same cycle as the ack at 0x10.
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    for (int n = 0; n < 40 && !(imem_req && imem_addr == 8'h10 && imem_ack); n++) tick();
    check("t4_ack_10", {31'b0, imem_ack}, 32'd1);
    redirect = 1'b1;
    redirect_pc = 8'h23;
    tick();
    redirect = 1'b0;
    check("t4_addr_new", {24'b0, imem_addr}, 32'h20);
    check("t4_valid_low", {31'b0, if_valid}, 32'd0);
    for (int n = 0; n < 10 && !if_valid; n++) tick();
    check("t4_pc_new", {24'b0, if_pc}, 32'h20);

    // 6: async reset with a request outstanding and if_valid high.
    lat = 3;
    id_ready = 1'b0;
    for (int n = 0; n < 40 && !(if_valid && imem_req && !imem_ack); n++) tick();
    check("t6_pre_valid", {31'b0, if_valid}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("t6_req_low", {31'b0, imem_req}, 32'd0);
    check("t6_valid_low", {31'b0, if_valid}, 32'd0);
    check("t6_pc_zero", {24'b0, if_pc}, 32'h00);
    check("t6_pc4_zero", {24'b0, if_pc_plus4}, 32'h00);
    check("t6_addr_rst", {24'b0, imem_addr}, 32'h00);
    lat = 0;
    id_ready = 1'b1;
    tick(); tick();
    reset = 1'b1;
    for (int n = 0; n < 10 && !imem_req; n++) tick();
    check("t6_first_addr", {24'b0, imem_addr}, 32'h00);
    for (int n = 0; n < 10 && !if_valid; n++) tick();
    check("t6_first_pc", {24'b0, if_pc}, 32'h00);
    check("t6_first_instr", if_instr, 32'h0C00_0000);
    for (int n = 0; n < 6; n++) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
